// File: rtl/pwm_pkg.sv
// Shared constants for the PWM period counter slice.
// Default tick width and the reset values of the active registers.
package pwm_pkg;

  localparam int unsigned PWM_BITWIDTH = 10;

  // Replicated across the tick width: the period resets to all ones,
  // and the edge tick numbers reset to zero.
  localparam logic PERIOD_RESET_BIT = 1'b1;
  localparam logic EDGE_RESET_BIT   = 1'b0;

  function automatic int unsigned shadow_width(
    input int unsigned bitwidth
  );
    return 3 * bitwidth;
  endfunction

endpackage

// File: rtl/pwm_shadow_register.sv
// One-deep pending buffer with a valid/ready load side.
// Holds a word until the owner consumes it with take.
module pwm_shadow_register #(
  parameter int unsigned width = 30
) (
  input  logic             clock,
  input  logic             reset,
  input  logic             load_valid,
  output logic             load_ready,
  input  logic [width-1:0] load_data,
  input  logic             take,
  output logic [width-1:0] data,
  output logic             full
);

  assign load_ready = ~full;

  // take is only raised while full, so it never races a load.
  always_ff @(posedge clock or negedge reset) begin
    if (!reset) begin
      full <= 1'b0;
      data <= '0;
    end else if (load_valid && !full) begin
      full <= 1'b1;
      data <= load_data;
    end else if (take) begin
      full <= 1'b0;
    end
  end

endmodule

// File: rtl/pwm_period_counter.sv
// PWM period counter with shadowed period and edge tick numbers.
// New settings are swapped in only at a period boundary.
module pwm_period_counter
  import pwm_pkg::*;
#(
  parameter int unsigned bitwidth = PWM_BITWIDTH
) (
  input  logic                clock,
  input  logic                reset,
  input  logic                enable,
  input  logic                update_valid,
  output logic                update_ready,
  input  logic [bitwidth-1:0] period_in,
  input  logic [bitwidth-1:0] rise_in,
  input  logic [bitwidth-1:0] fall_in,
  output logic [bitwidth-1:0] counter,
  output logic [bitwidth-1:0] tick_number_rising_edge,
  output logic [bitwidth-1:0] tick_number_falling_edge,
  output logic                wrap
);

  localparam int unsigned SW = shadow_width(bitwidth);

  localparam logic [bitwidth-1:0] PERIOD_RESET =
    {bitwidth{PERIOD_RESET_BIT}};
  localparam logic [bitwidth-1:0] EDGE_RESET =
    {bitwidth{EDGE_RESET_BIT}};

  logic [bitwidth-1:0] active_period;
  logic [SW-1:0]       pending;
  logic                pending_full;
  logic                wrap_event;
  logic                apply;

  assign wrap_event = enable && (counter == active_period);
  assign apply      = wrap_event && pending_full;

  pwm_shadow_register #(
    .width(SW)
  ) u_shadow (
    .clock     (clock),
    .reset     (reset),
    .load_valid(update_valid),
    .load_ready(update_ready),
    .load_data ({period_in, rise_in, fall_in}),
    .take      (apply),
    .data      (pending),
    .full      (pending_full)
  );

  // A set loaded on a wrap edge sees pending_full=0 there,
  // so it waits for the next boundary.
  always_ff @(posedge clock or negedge reset) begin
    if (!reset) begin
      counter                  <= '0;
      wrap                     <= 1'b0;
      active_period            <= PERIOD_RESET;
      tick_number_rising_edge  <= EDGE_RESET;
      tick_number_falling_edge <= EDGE_RESET;
    end else begin
      wrap <= wrap_event;
      if (enable) begin
        counter <= wrap_event ? '0 : counter + 1'b1;
      end
      if (apply) begin
        {active_period,
         tick_number_rising_edge,
         tick_number_falling_edge} <= pending;
      end
    end
  end

endmodule

// File: tb/tb_pwm_period_counter.sv
// Directed bench for pwm_period_counter at bitwidth 10.
// Vector table plus hand sequences for reset and long runs.
module tb_pwm_period_counter;

  localparam int W = 10;

  logic         clock;
  logic         reset;
  logic         enable;
  logic         update_valid;
  logic         update_ready;
  logic [W-1:0] period_in;
  logic [W-1:0] rise_in;
  logic [W-1:0] fall_in;
  logic [W-1:0] counter;
  logic [W-1:0] rise_o;
  logic [W-1:0] fall_o;
  logic         wrap;

  int n_cmp;
  int n_bad;

  typedef struct {
    logic         en;
    logic         uv;
    logic [W-1:0] per;
    logic [W-1:0] ri;
    logic [W-1:0] fa;
    logic [W-1:0] cnt;
    logic         w;
    logic         rdy;
    logic [W-1:0] er;
    logic [W-1:0] ef;
  } vec_t;

  vec_t tv[$];

  pwm_period_counter #(
    .bitwidth(W)
  ) dut (
    .clock                   (clock),
    .reset                   (reset),
    .enable                  (enable),
    .update_valid            (update_valid),
    .update_ready            (update_ready),
    .period_in               (period_in),
    .rise_in                 (rise_in),
    .fall_in                 (fall_in),
    .counter                 (counter),
    .tick_number_rising_edge (rise_o),
    .tick_number_falling_edge(fall_o),
    .wrap                    (wrap)
  );

  initial clock = 1'b0;
  always #5 clock = ~clock;

  initial begin
    #100000;
    $display("FAIL watchdog: time limit reached");
    $fatal(1);
  end

  task automatic chk(
    input string       name,
    input logic [31:0] act,
    input logic [31:0] exp
  );
    n_cmp++;
    if (act !== exp) begin
      n_bad++;
      $display("FAIL %s: got %0d want %0d", name, act, exp);
    end
  endtask

  task automatic chk_all(
    input string        tag,
    input logic [W-1:0] c,
    input logic         w,
    input logic         r,
    input logic [W-1:0] er,
    input logic [W-1:0] ef
  );
    chk({tag, " counter"}, 32'(counter), 32'(c));
    chk({tag, " wrap"}, 32'(wrap), 32'(w));
    chk({tag, " ready"}, 32'(update_ready), 32'(r));
    chk({tag, " rise"}, 32'(rise_o), 32'(er));
    chk({tag, " fall"}, 32'(fall_o), 32'(ef));
  endtask

  task automatic add(
    input logic en, input logic uv,
    input int per, input int ri, input int fa,
    input int cnt, input logic w, input logic rdy,
    input int er, input int ef
  );
    vec_t v;
    v.en  = en;
    v.uv  = uv;
    v.per = W'(per);
    v.ri  = W'(ri);
    v.fa  = W'(fa);
    v.cnt = W'(cnt);
    v.w   = w;
    v.rdy = rdy;
    v.er  = W'(er);
    v.ef  = W'(ef);
    tv.push_back(v);
  endtask

  initial begin
    logic [W-1:0] ec;
    logic         ew;
    logic         er;
    n_cmp = 0;
    n_bad = 0;

    // Starts with period 9, rise 2, fall 7, counter 0.
    add(1,0,0,0,0, 1,0,1, 2,7);
    add(1,0,0,0,0, 2,0,1, 2,7);
    add(1,0,0,0,0, 3,0,1, 2,7);
    add(1,0,0,0,0, 4,0,1, 2,7);
    for (int i = 0; i < 5; i++)
      add(0,0,0,0,0, 4,0,1, 2,7);
    add(1,0,0,0,0, 5,0,1, 2,7);
    add(1,1,0,5,3, 6,0,0, 2,7);
    add(1,1,4,1,1, 7,0,0, 2,7);
    add(1,0,0,0,0, 8,0,0, 2,7);
    add(1,0,0,0,0, 9,0,0, 2,7);
    add(1,0,0,0,0, 0,1,1, 5,3);
    add(1,0,0,0,0, 0,1,1, 5,3);
    add(1,0,0,0,0, 0,1,1, 5,3);
    add(0,0,0,0,0, 0,0,1, 5,3);
    add(1,0,0,0,0, 0,1,1, 5,3);
    add(1,1,3,1,2, 0,1,0, 5,3);
    add(1,0,0,0,0, 0,1,1, 1,2);
    add(1,0,0,0,0, 1,0,1, 1,2);
    add(1,0,0,0,0, 2,0,1, 1,2);
    add(1,0,0,0,0, 3,0,1, 1,2);
    add(1,1,5,4,0, 0,1,0, 1,2);
    add(1,0,0,0,0, 1,0,0, 1,2);
    add(1,0,0,0,0, 2,0,0, 1,2);
    add(1,0,0,0,0, 3,0,0, 1,2);
    add(1,0,0,0,0, 0,1,1, 4,0);
    add(1,0,0,0,0, 1,0,1, 4,0);
    add(1,1,9,3,4, 2,0,0, 4,0);
    add(1,0,0,0,0, 3,0,0, 4,0);
    add(1,0,0,0,0, 4,0,0, 4,0);
    add(1,0,0,0,0, 5,0,0, 4,0);
    add(1,0,0,0,0, 0,1,1, 3,4);
    add(1,1,2,8,8, 1,0,0, 3,4);
    for (int i = 2; i <= 6; i++)
      add(1,0,0,0,0, i,0,0, 3,4);

    reset        = 1'b0;
    enable       = 1'b0;
    update_valid = 1'b0;
    period_in    = '0;
    rise_in      = '0;
    fall_in      = '0;

    repeat (2) @(posedge clock);
    #1;
    chk_all("reset", 0, 0, 1, 0, 0);

    @(negedge clock);
    reset  = 1'b1;
    enable = 1'b1;

    // Full-range run with an update at 500 and an ignored second offer.
    for (int i = 1; i <= 1024; i++) begin
      if (i == 501) begin
        update_valid = 1'b1;
        period_in    = 10'd9;
        rise_in      = 10'd2;
        fall_in      = 10'd7;
      end else if (i == 502) begin
        period_in = 10'd4;
        rise_in   = 10'd1;
        fall_in   = 10'd1;
      end else if (i == 511) begin
        update_valid = 1'b0;
      end
      @(posedge clock);
      #1;
      ec = W'(i % 1024);
      ew = (i == 1024);
      er = (i < 501) || (i == 1024);
      if (i == 1024)
        chk_all("boundary", ec, ew, er, 2, 7);
      else
        chk_all($sformatf("run%0d", i), ec, ew, er, 0, 0);
    end

    foreach (tv[k]) begin
      enable       = tv[k].en;
      update_valid = tv[k].uv;
      period_in    = tv[k].per;
      rise_in      = tv[k].ri;
      fall_in      = tv[k].fa;
      @(posedge clock);
      #1;
      chk_all($sformatf("vec%0d", k),
              tv[k].cnt, tv[k].w, tv[k].rdy,
              tv[k].er, tv[k].ef);
    end

    // Asynchronous reset mid-cycle with period 2 still pending.
    update_valid = 1'b0;
    #2;
    reset = 1'b0;
    #1;
    chk_all("async_rst", 0, 0, 1, 0, 0);

    @(negedge clock);
    reset  = 1'b1;
    enable = 1'b1;
    for (int i = 1; i <= 4; i++) begin
      @(posedge clock);
      #1;
      chk_all($sformatf("post_rst%0d", i), W'(i), 0, 1, 0, 0);
    end

    $display("*** SUMMARY: %0d compared / %0d mismatched ***",
             n_cmp, n_bad);
    $finish;
  end

endmodule

// File: doc/pwm_period_counter.md
PWM_PERIOD_COUNTER -- requirements
Module: pwm_period_counter

Interface
REQ-001 Parameter: bitwidth, default 10, width of counter, period and edge tick numbers.
REQ-002 The block SHALL have one clock and an asynchronous, active-low reset, with ports named clock and reset.
REQ-003 clock  input  1  rising-edge clock for all state.
REQ-004 reset  input  1  asynchronous active-low reset; 0 = in reset.
REQ-005 enable  input  1  1 = counter advances this cycle; 0 = all counting state holds.
REQ-006 update_valid  input  1  new period/edge set offered.
REQ-007 update_ready  output  1  block can accept a new set this cycle.
REQ-008 period_in  input  bitwidth  requested terminal count; the PWM period is period_in+1 ticks.
REQ-009 rise_in  input  bitwidth  requested rising-edge tick number.
REQ-010 fall_in  input  bitwidth  requested falling-edge tick number.
REQ-011 counter  output  bitwidth  running tick count, registered.
REQ-012 tick_number_rising_edge  output  bitwidth  active rising-edge tick, registered.
REQ-013 tick_number_falling_edge  output  bitwidth  active falling-edge tick, registered.
REQ-014 wrap  output  1  one-cycle pulse marking period start, registered.

Function
REQ-015 Counting: on each rising clock edge with enable=1, counter SHALL increment by 1 if counter != active_period, otherwise load 0 (wrap event).
REQ-016 With enable=0, counter, active values, pending buffer and wrap SHALL hold, except that wrap SHALL clear to 0.
REQ-017 wrap SHALL be 1 for exactly the one cycle in which counter has just been loaded with 0 by a wrap event, and 0 otherwise.
REQ-018 Handshake: an update SHALL be accepted on a rising edge where update_valid=1 and update_ready=1; the inputs are then captured into a one-deep pending buffer.
REQ-019 update_ready SHALL equal NOT pending_full, where pending_full is a register.
REQ-020 On a wrap event with pending_full=1, active_period, tick_number_rising_edge and tick_number_falling_edge SHALL load the pending values on the same edge that counter loads 0, and pending_full SHALL clear.
REQ-021 Latency: accepted values SHALL become visible on the outputs at the first wrap event strictly after acceptance; they SHALL never take effect mid-period.
REQ-022 An update accepted on the same edge as a wrap event SHALL be buffered and applied at the following wrap event, not at the current one.
REQ-023 update_ready SHALL return to 1 in the cycle after the apply edge.
REQ-024 update_valid while update_ready=0 SHALL be ignored; the inputs SHALL NOT be captured and the buffer SHALL NOT be overwritten.
REQ-025 active_period=0: counter SHALL stay 0, and a wrap event SHALL occur on every enabled edge.
REQ-026 The block SHALL NOT check rise_in/fall_in against period_in; values greater than the period pass through unchanged.
REQ-027 Counter arithmetic SHALL be unsigned bitwidth-bit; an all-ones period wraps to 0 without overflow to other state.

Reset
REQ-028 When reset=0, the block SHALL asynchronously set: counter=0, wrap=0, pending_full=0 (update_ready=1), active_period=2^bitwidth-1, tick_number_rising_edge=0, tick_number_falling_edge=0.
REQ-029 Any pending update SHALL be discarded on reset.
REQ-030 Counting SHALL resume from 0 on the first enabled edge after reset deasserts.

Structure
REQ-031 The shared package pwm_pkg SHALL hold the default bitwidth and the reset constants for period and edge tick numbers.
REQ-032 The pending buffer plus its valid/ready flag SHALL be a sub-module pwm_shadow_register, instantiated once with width 3*bitwidth.
REQ-033 The counter and apply logic SHALL reside in pwm_period_counter.

Verification (bitwidth=10)
REQ-034 Release reset with enable=1 and no update -> counter runs 0..1023, wrap=1 when counter returns to 0 after 1024 cycles, edge outputs stay 0.
REQ-035 At counter=500, accept period=9, rise=2, fall=7 -> outputs unchanged until 1023->0; then edge outputs=2/7, counter cycles 0..9, wrap every 10 cycles.
REQ-036 Offer a second set (period=4) while pending -> update_ready=0, second set ignored, first set applied at wrap, update_ready=1 on the next cycle.
REQ-037 Apply period=0 -> counter stays 0 and wrap=1 on every enabled cycle; deassert enable for 5 cycles at counter=4 under period=9 -> counter holds 4 with wrap=0, then continues from 5.
REQ-038 Assert reset at counter=6 with an update pending -> counter=0, update_ready=1 and edge outputs=0 immediately, without a clock edge; the pending set is never applied.
REQ-039 Accept an update on the exact wrap edge -> values are applied at the next wrap, one full period later.
